step_dir_receiver: RTL

STEP_DIR_RECEIVER -- requirements
Module: step_dir_receiver

---
 rtl/stepdir_pkg.sv | 66 ++++++
 rtl/step_input_filter.sv | 42 ++++
 rtl/step_dir_receiver.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/stepdir_pkg.sv
// Shared constants for the step/dir receiver: register offsets, CONFIG and
// STATUS bit positions, filter width, reset values and config helpers.
package stepdir_pkg;

    localparam int unsigned FiltW = 3;

    // Register offsets relative to the instance base address
    localparam logic [7:0] OffConfig   = 8'd0;
    localparam logic [7:0] OffStatus   = 8'd1;
    localparam logic [7:0] OffPosition = 8'd2;
    localparam logic [7:0] OffCompare  = 8'd3;
    localparam logic [7:0] OffPeriod   = 8'd4;

    // CONFIG bit positions
    localparam int unsigned CfgStepPol = 0;
    localparam int unsigned CfgDirPol  = 1;
    localparam int unsigned CfgCntEn   = 2;
    localparam int unsigned CfgFiltLsb = 4;

    // STATUS bit positions
    localparam int unsigned StsDir   = 0;
    localparam int unsigned StsWrap  = 1;
    localparam int unsigned StsDrop  = 2;
    localparam int unsigned StsMatch = 3;

    // Reset constants
    localparam logic [7:0]  ConfigReset   = 8'h05;
    localparam logic [31:0] PositionReset = 32'h0000_0000;
    localparam logic [31:0] CompareReset  = 32'h0000_0000;

    // Reply sizes in bytes
    localparam logic [2:0] SizeNone = 3'd0;
    localparam logic [2:0] SizeByte = 3'd1;
    localparam logic [2:0] SizeWord = 3'd4;

    // Two's complement extremes of POSITION
    localparam logic [31:0] PosMax = 32'h7fff_ffff;
    localparam logic [31:0] PosMin = 32'h8000_0000;

    typedef struct packed {
        logic [FiltW-1:0] filt;
        logic             cnt_en;
        logic             dir_pol;
        logic             step_pol;
    } config_t;

    function automatic config_t unpack_config(input logic [7:0] b);
        config_t c;
        c.step_pol = b[CfgStepPol];
        c.dir_pol  = b[CfgDirPol];
        c.cnt_en   = b[CfgCntEn];
        c.filt     = b[CfgFiltLsb +: FiltW];
        return c;
    endfunction

    function automatic logic [7:0] pack_config(input config_t c);
        logic [7:0] b;
        b = 8'h00;
        b[CfgStepPol]            = c.step_pol;
        b[CfgDirPol]             = c.dir_pol;
        b[CfgCntEn]              = c.cnt_en;
        b[CfgFiltLsb +: FiltW]   = c.filt;
        return b;
    endfunction

endpackage

// File: rtl/step_input_filter.sv
// Two-flop synchronizer followed by a programmable glitch filter. The output
// only follows the synchronized input after it has held a new level for
// filt+1 consecutive clocks.
module step_input_filter
    import stepdir_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [FiltW-1:0] filt,
    input  logic             din,
    output logic             dout
);

    logic             sync1_q;
    logic             sync2_q;
    logic [FiltW-1:0] cnt_q;

    // Synchronize the pin, then count consecutive clocks of disagreement.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            dout    <= 1'b0;
        end else begin
            sync1_q <= din;
            sync2_q <= sync1_q;
            if (sync2_q != dout) begin
                // >= keeps the filter live if filt is lowered mid-count
                if (cnt_q >= filt) begin
                    dout  <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

endmodule

// File: rtl/step_dir_receiver.sv
// Step/direction receiver: filters the step and dir pins, counts active step
// edges into a signed POSITION and exposes CONFIG/STATUS/POSITION/COMPARE on
// a shared register bus. Optional PERIOD rate monitor at offset +4 is built
// when STEPRX_RATE_MON_EN is defined.
module step_dir_receiver
    import stepdir_pkg::*;
#(
    parameter logic [7:0] axis_haddr = 8'h00
)
(
    input  logic        clk_12MHz,
    input  logic        reset,
    inout  tri   [31:0] databus,
    output tri   [2:0]  reg_size,
    input  logic [7:0]  register_addr,
    input  logic        rw,
    input  logic        select,
    input  logic        step_in,
    input  logic        dir_in,
    output logic        match
);

    config_t     cfg_q;
    logic [31:0] position_q;
    logic [31:0] compare_q;
    logic        wrap_q;
    logic        drop_q;

    logic        step_filt;
    logic        dir_filt;
    logic        step_prev_q;

    logic        sel_prev_q;
    logic        wr_pend_q;
    logic [7:0]  wr_off_q;
    logic [31:0] wr_data_q;
    logic [31:0] rd_data_q;
    logic [2:0]  rd_size_q;

    logic [7:0]  bus_off;
    logic        sel_rise;

    logic        step_edge;
    logic        step_fire;
    logic        step_taken;
    logic        count_up;
    logic        wr_cfg;
    logic        wr_sts;
    logic        wr_pos;
    logic        wr_cmp;
    logic [31:0] pos_stepped;
    logic        wrap_set;
    logic        wrap_clr;
    logic        drop_set;
    logic        drop_clr;
    logic [7:0]  status_byte;
    logic [31:0] rd_value;
    logic [2:0]  rd_size;

`ifdef STEPRX_RATE_MON_EN
    logic [31:0] period_q;
    logic [31:0] since_q;
    logic        armed_q;
`endif

    step_input_filter u_step_filter (
        .clk   (clk_12MHz),
        .reset (reset),
        .filt  (cfg_q.filt),
        .din   (step_in),
        .dout  (step_filt)
    );

    step_input_filter u_dir_filter (
        .clk   (clk_12MHz),
        .reset (reset),
        .filt  (cfg_q.filt),
        .din   (dir_in),
        .dout  (dir_filt)
    );

    assign bus_off  = register_addr - axis_haddr;
    assign sel_rise = select & ~sel_prev_q;
    assign match    = (position_q == compare_q);

    // Edge detection, pending-write decode and sticky flag set/clear terms.
    always_comb begin
        // Only filtered transitions are edges, so a polarity change alone never counts
        step_edge   = cfg_q.step_pol ? (step_filt & ~step_prev_q)
                                     : (~step_filt & step_prev_q);
        step_fire   = step_edge & cfg_q.cnt_en;
        count_up    = dir_filt ^ cfg_q.dir_pol;
        wr_cfg      = wr_pend_q & (wr_off_q == OffConfig);
        wr_sts      = wr_pend_q & (wr_off_q == OffStatus);
        wr_pos      = wr_pend_q & (wr_off_q == OffPosition);
        wr_cmp      = wr_pend_q & (wr_off_q == OffCompare);
        // A coinciding POSITION write wins and the step is dropped
        step_taken  = step_fire & ~wr_pos;
        pos_stepped = count_up ? (position_q + 32'd1) : (position_q - 32'd1);
        wrap_set    = step_taken & (count_up ? (position_q == PosMax)
                                             : (position_q == PosMin));
        drop_set    = step_fire & wr_pos;
        wrap_clr    = wr_sts & wr_data_q[StsWrap];
        drop_clr    = wr_sts & wr_data_q[StsDrop];
    end

    // Core registers: config, position counter, compare and sticky flags.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            cfg_q       <= unpack_config(ConfigReset);
            position_q  <= PositionReset;
            compare_q   <= CompareReset;
            wrap_q      <= 1'b0;
            drop_q      <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_prev_q <= step_filt;
            if (wr_cfg) begin
                cfg_q <= unpack_config(wr_data_q[7:0]);
            end
            if (wr_cmp) begin
                compare_q <= wr_data_q;
            end
            if (wr_pos) begin
                position_q <= wr_data_q;
            end else if (step_taken) begin
                position_q <= pos_stepped;
            end
            // Set beats clear when both land in the same clock
            wrap_q <= (wrap_q & ~wrap_clr) | wrap_set;
            drop_q <= (drop_q & ~drop_clr) | drop_set;
        end
    end

`ifdef STEPRX_RATE_MON_EN
    // Clock count between the last two accepted edges, saturating.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            period_q <= 32'h0;
            since_q  <= 32'h0;
            armed_q  <= 1'b0;
        end else if (step_taken) begin
            if (armed_q) begin
                period_q <= since_q;
            end
            armed_q <= 1'b1;
            since_q <= 32'd1;
        end else if (since_q != 32'hffff_ffff) begin
            since_q <= since_q + 32'd1;
        end
    end
`endif

    // Read mux for the value latched on a select rising edge.
    always_comb begin
        status_byte           = 8'h00;
        status_byte[StsDir]   = count_up;
        status_byte[StsWrap]  = wrap_q;
        status_byte[StsDrop]  = drop_q;
        status_byte[StsMatch] = match;
        rd_value              = 32'h0;
        rd_size               = SizeNone;
        case (bus_off)
            OffConfig: begin
                rd_value = {24'h0, pack_config(cfg_q)};
                rd_size  = SizeByte;
            end
            OffStatus: begin
                rd_value = {24'h0, status_byte};
                rd_size  = SizeByte;
            end
            OffPosition: begin
                rd_value = position_q;
                rd_size  = SizeWord;
            end
            OffCompare: begin
                rd_value = compare_q;
                rd_size  = SizeWord;
            end
`ifdef STEPRX_RATE_MON_EN
            OffPeriod: begin
                rd_value = period_q;
                rd_size  = SizeWord;
            end
`endif
            default: begin
                rd_value = 32'h0;
                rd_size  = SizeNone;
            end
        endcase
    end

    // Bus front end: select edge detect, write capture, read latch.
    always_ff @(posedge clk_12MHz or posedge reset) begin
        if (reset) begin
            sel_prev_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            wr_off_q   <= 8'h0;
            wr_data_q  <= 32'h0;
            rd_data_q  <= 32'h0;
            rd_size_q  <= SizeNone;
        end else begin
            sel_prev_q <= select;
            // Captured writes are applied one clock after detection
            wr_pend_q  <= sel_rise & ~rw;
            if (sel_rise & ~rw) begin
                wr_off_q  <= bus_off;
                wr_data_q <= databus;
            end
            if (sel_rise) begin
                rd_data_q <= rd_value;
                rd_size_q <= rd_size;
            end
        end
    end

    assign databus  = (select & rw) ? rd_data_q : 32'hzzzz_zzzz;
    assign reg_size = select ? rd_size_q : 3'bzzz;

endmodule
